// File: rtl/rca_arb_pkg.sv
// Shared types, range constants and grant selection for rca_arbiter.
// Grant selection serves both fixed-priority (pointer 0) and round-robin modes.
package rca_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 8;
  localparam int GIDW     = 3;  // index width covering NREQ_MAX requesters

  // First valid index at or after ptr, searching upward and wrapping at nreq-1.
  function automatic logic [GIDW-1:0] sel_grant(input logic [NREQ_MAX-1:0] valid,
                                                input logic [GIDW-1:0]     ptr,
                                                input int                  nreq);
    logic [GIDW-1:0] g;
    logic            found;
    int              idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      idx = int'(ptr) + i;
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (i < nreq) && valid[idx[GIDW-1:0]]) begin
        g     = idx[GIDW-1:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rca_adder_core.sv
// Registered WIDTH-bit ripple-carry adder: full-adder chain feeding an
// output register that captures {cout, sum} only while en is high.
module rca_adder_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   sum_q;

  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]         = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= {carry[WIDTH], s};
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/rca_arbiter.sv
// Shares one registered ripple-carry adder among NREQ requesters (IDLE/EXEC/RESP).
// Define RCA_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority.
module rca_arbiter
  import rca_arb_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH:0]        rsp_sum,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("rca_arbiter: NREQ out of range");
  end

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic                cin_q, cin_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      ptr;
  logic [GIDW-1:0]     grant_full;
  logic [IDW-1:0]      grant;
  logic [NREQ_MAX-1:0] valid_ext;
  logic                accept;
  logic                exec_en;

  assign valid_ext  = NREQ_MAX'(req_valid);
  assign grant_full = sel_grant(valid_ext, GIDW'(ptr), NREQ);
  assign grant      = grant_full[IDW-1:0];
  // Gated by rst so nothing is offered while reset holds the FSM.
  assign accept     = (state_q == IDLE) && rst && (|req_valid);

`ifdef RCA_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = req_a[int'(grant)*WIDTH +: WIDTH];
          b_d     = req_b[int'(grant)*WIDTH +: WIDTH];
          cin_d   = req_cin[grant];
          id_d    = grant;
          state_d = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  // NOTE: operand/ID registers are reset too, since rsp_id must read 0 out of reset;
  // sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      id_q    <= id_d;
    end
  end

  assign exec_en = (state_q == EXEC);

  rca_adder_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .en  (exec_en),
    .a   (a_q),
    .b   (b_q),
    .cin (cin_q),
    .sum (rsp_sum)
  );

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;

endmodule
